ex_iter: RTL and testbench

Parametrised execute stage for the mcpu pipeline, sitting between the ID/EX and EX/MEM boundaries. It evaluates single-cycle ALU operations and an iterative unsigned multiply/divide unit, registering every result into the EX/MEM output register. Multi-cycle operations raise a stall request toward the pipeline controller until their result is written.

---
 rtl/ex_iter.sv | 136 +++++++++++++
 tb/tb_ex_iter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_iter.sv
// ex_iter: mcpu execute stage with single-cycle ALU and iterative unsigned mul/div feeding the EX/MEM register
module ex_iter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              valid_i,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [SEL_W-1:0]  alusel_i,
  input  logic [DATA_W-1:0] reg0_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              we_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic              valid_o,
  output logic              stall_req_o
);
  localparam int SW = $clog2(DATA_W);
  // Jump and load classes (codes 0 and 7) produce nothing here and fall to the zero default.
  localparam logic [SEL_W-1:0] SEL_REG    = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LOGIC  = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_SHIFT  = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_ARITH  = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_CMP    = SEL_W'(5);
  localparam logic [SEL_W-1:0] SEL_MULDIV = SEL_W'(6);
  localparam logic [OP_W-1:0] OP_LI   = OP_W'(8'h0F);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(8'h24);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(8'h25);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(8'h26);
  localparam logic [OP_W-1:0] OP_NOR  = OP_W'(8'h27);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(8'h7C);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8'h03);
  localparam logic [OP_W-1:0] OP_ADDU = OP_W'(8'h21);
  localparam logic [OP_W-1:0] OP_SUBU = OP_W'(8'h23);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8'h2A);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(8'h2B);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(8'h18);
  localparam logic [OP_W-1:0] OP_DIVU = OP_W'(8'h1B);
  localparam logic [OP_W-1:0] OP_REMU = OP_W'(8'h1C);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [SW-1:0]     cnt;
  logic [DATA_W-1:0] res, x, y, acc, md_res, diff;
  logic [DATA_W:0]   t;
  logic [OP_W-1:0]   md_op;
  logic [ADDR_W-1:0] md_waddr;
  logic              md_we, is_md, start, lt, ge, is_mul;
  logic [SW-1:0]     sh;

  assign sh     = reg1_i[SW-1:0];
  assign lt     = aluop_i == OP_SLT ? $signed(reg0_i) < $signed(reg1_i) : reg0_i < reg1_i;
  assign is_md  = valid_i && alusel_i == SEL_MULDIV;
  assign start  = state == IDLE && is_md && !stall_i;
  assign is_mul = md_op == OP_MUL;
  assign t      = {acc, x[DATA_W-1]};
  assign ge     = t >= {1'b0, y};
  assign diff   = t[DATA_W-1:0] - y;
  assign md_res = is_mul ? acc : md_op == OP_DIVU ? x : md_op == OP_REMU ? acc : '0;

  always_comb begin
    res = '0;
    case (alusel_i)
      SEL_REG:   res = aluop_i == OP_LI ? reg0_i : '0;
      SEL_LOGIC: res = aluop_i == OP_AND ? reg0_i & reg1_i :
                       aluop_i == OP_OR  ? reg0_i | reg1_i :
                       aluop_i == OP_XOR ? reg0_i ^ reg1_i :
                       aluop_i == OP_NOR ? ~(reg0_i | reg1_i) : '0;
      SEL_SHIFT: res = aluop_i == OP_SLL ? reg0_i << sh :
                       aluop_i == OP_SRL ? reg0_i >> sh :
                       aluop_i == OP_SRA ? $unsigned($signed(reg0_i) >>> sh) : '0;
      SEL_ARITH: res = aluop_i == OP_ADDU ? reg0_i + reg1_i :
                       aluop_i == OP_SUBU ? reg0_i - reg1_i : '0;
      SEL_CMP:   res = (aluop_i == OP_SLT || aluop_i == OP_SLTU) ? {{(DATA_W-1){1'b0}}, lt} : '0;
      default:   res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      waddr_o <= '0;
      wdata_o <= '0;
      we_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= state == RUN ? cnt + 1'b1 : '0;
      if (state == IDLE && !stall_i) begin
        waddr_o <= waddr_i;
        wdata_o <= start ? '0 : res;
        we_o    <= !start && we_i && valid_i;
        valid_o <= !start && valid_i;
      end else if (state == DONE && !stall_i) begin
        waddr_o <= md_waddr;
        wdata_o <= md_res;
        we_o    <= md_we;
        valid_o <= 1'b1;
      end
    end
  end

  // Shared operand registers: x is multiplicand or dividend/quotient, acc is product or partial remainder.
  always_ff @(posedge clk) begin
    if (start) begin
      x        <= reg0_i;
      y        <= reg1_i;
      acc      <= '0;
      md_op    <= aluop_i;
      md_waddr <= waddr_i;
      md_we    <= we_i;
    end else if (state == RUN) begin
      acc <= is_mul ? acc + (y[0] ? x : '0) : ge ? diff : t[DATA_W-1:0];
      x   <= is_mul ? x << 1 : {x[DATA_W-2:0], ge};
      y   <= is_mul ? y >> 1 : y;
    end
  end

  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? (cnt == SW'(DATA_W-1) ? DONE : RUN) :
          (stall_i ? DONE : IDLE);
  end

  always_comb begin
    stall_req_o = !rst && ((state == IDLE && is_md) || state == RUN);
  end
endmodule

// File: tb/tb_ex_iter.sv
// tb_ex_iter: vector table, random single-cycle ops and multi-cycle mul/div sequences against a behavioural model
module tb_ex_iter;
  localparam logic [2:0] S_SPEC = 3'd0, S_REG = 3'd1, S_LOGIC = 3'd2, S_SHIFT = 3'd3,
                         S_ARITH = 3'd4, S_CMP = 3'd5, S_MD = 3'd6, S_JUMP = 3'd7;
  localparam logic [7:0] O_LI = 8'h0F, O_AND = 8'h24, O_OR = 8'h25, O_XOR = 8'h26, O_NOR = 8'h27,
                         O_SLL = 8'h7C, O_SRL = 8'h02, O_SRA = 8'h03, O_ADDU = 8'h21, O_SUBU = 8'h23,
                         O_SLT = 8'h2A, O_SLTU = 8'h2B, O_MUL = 8'h18, O_DIVU = 8'h1B, O_REMU = 8'h1C;

  logic clk = 0, rst, stall_i, valid_i, we_i, we_o, valid_o, stall_req_o;
  logic [7:0] aluop_i;
  logic [2:0] alusel_i;
  logic [31:0] reg0_i, reg1_i, wdata_o;
  logic [4:0] waddr_i, waddr_o;
  int n_cmp = 0, n_bad = 0;

  ex_iter dut (.clk(clk), .rst(rst), .stall_i(stall_i), .valid_i(valid_i), .aluop_i(aluop_i),
    .alusel_i(alusel_i), .reg0_i(reg0_i), .reg1_i(reg1_i), .waddr_i(waddr_i), .we_i(we_i),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o), .valid_o(valid_o), .stall_req_o(stall_req_o));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0] sel; logic [7:0] op; logic [31:0] a, b; logic [4:0] wa; logic we, v; logic [31:0] exp;
  } vec_t;
  vec_t tbl[17];

  function automatic logic [31:0] model(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a, b);
    int sh;
    sh = int'(b[4:0]);
    case (s)
      S_REG:   return o == O_LI ? a : 32'd0;
      S_LOGIC: return o == O_AND ? a & b : o == O_OR ? a | b : o == O_XOR ? a ^ b : o == O_NOR ? ~(a | b) : 32'd0;
      S_SHIFT: return o == O_SLL ? a << sh : o == O_SRL ? a >> sh : o == O_SRA ? $unsigned($signed(a) >>> sh) : 32'd0;
      S_ARITH: return o == O_ADDU ? a + b : o == O_SUBU ? a - b : 32'd0;
      S_CMP:   return o == O_SLT ? {31'd0, $signed(a) < $signed(b)} : o == O_SLTU ? {31'd0, a < b} : 32'd0;
      S_MD:    return o == O_MUL ? a * b : o == O_DIVU ? (b == 0 ? 32'hFFFFFFFF : a / b) :
                      o == O_REMU ? (b == 0 ? a : a % b) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a, b,
                       input logic [4:0] wa, input logic we, v);
    alusel_i = s; aluop_i = o; reg0_i = a; reg1_i = b; waddr_i = wa; we_i = we; valid_i = v;
  endtask

  task automatic run_md(input logic [7:0] op, input logic [31:0] a, b, input int holds, input logic rnd,
                        input logic [2:0] ns, input logic [7:0] nop, input logic [31:0] na, nb);
    int c;
    stall_i = 0;
    drive(S_MD, op, a, b, 5'd7, 1'b1, 1'b1);
    #1;
    chk("md_req_start", {31'd0, stall_req_o}, 1);
    c = 0;
    while (stall_req_o && c < 100) begin
      stall_i = (rnd && c > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      c++;
      step();
      if (c == 1) begin
        chk("md_bubble_valid", {31'd0, valid_o}, 0);
        chk("md_bubble_we", {31'd0, we_o}, 0);
        chk("md_bubble_data", wdata_o, 0);
      end
    end
    stall_i = 0;
    chk("md_req_cycles", c, 33);
    for (int h = 0; h < holds; h++) begin
      stall_i = 1;
      #1;
      chk("done_hold_req", {31'd0, stall_req_o}, 0);
      step();
      chk("done_hold_valid", {31'd0, valid_o}, 0);
    end
    stall_i = 0;
    step();
    chk("md_result", wdata_o, model(S_MD, op, a, b));
    chk("md_valid", {31'd0, valid_o}, 1);
    chk("md_we", {31'd0, we_o}, 1);
    chk("md_waddr", {27'd0, waddr_o}, 7);
    drive(ns, nop, na, nb, 5'd9, 1'b1, 1'b1);
    #1;
    chk("next_no_req", {31'd0, stall_req_o}, 0);
    step();
    chk("next_result", wdata_o, model(ns, nop, na, nb));
    chk("next_waddr", {27'd0, waddr_o}, 9);
    chk("next_valid", {31'd0, valid_o}, 1);
    valid_i = 0;
  endtask

  initial begin
    logic [2:0] rs[13];
    logic [7:0] ro[13];
    int k;
    logic [31:0] a, b;
    tbl[0]  = '{S_ARITH, O_ADDU, 32'hFFFFFFFF, 32'h1, 5'd3, 1'b1, 1'b1, 32'h0};
    tbl[1]  = '{S_SHIFT, O_SRA, 32'h80000000, 32'h4, 5'd4, 1'b1, 1'b1, 32'hF8000000};
    tbl[2]  = '{S_CMP, O_SLT, 32'hFFFFFFFF, 32'h1, 5'd5, 1'b1, 1'b1, 32'h1};
    tbl[3]  = '{S_CMP, O_SLTU, 32'hFFFFFFFF, 32'h1, 5'd6, 1'b1, 1'b1, 32'h0};
    tbl[4]  = '{S_LOGIC, O_OR, 32'hF0F0, 32'h0F0F, 5'd7, 1'b1, 1'b1, 32'hFFFF};
    tbl[5]  = '{S_LOGIC, O_NOR, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1, 32'hFFFFFFFF};
    tbl[6]  = '{S_LOGIC, O_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 5'd9, 1'b1, 1'b1, 32'hF00FF00F};
    tbl[7]  = '{S_LOGIC, O_AND, 32'h12345678, 32'hFF00FF00, 5'd10, 1'b1, 1'b1, 32'h12005600};
    tbl[8]  = '{S_SHIFT, O_SLL, 32'h1, 32'd31, 5'd11, 1'b1, 1'b1, 32'h80000000};
    tbl[9]  = '{S_SHIFT, O_SRL, 32'h80000000, 32'h24, 5'd12, 1'b1, 1'b1, 32'h08000000};
    tbl[10] = '{S_ARITH, O_SUBU, 32'h0, 32'h1, 5'd13, 1'b1, 1'b1, 32'hFFFFFFFF};
    tbl[11] = '{S_REG, O_LI, 32'hDEADBEEF, 32'h0, 5'd14, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[12] = '{S_SPEC, 8'h00, 32'h1234, 32'h5678, 5'd15, 1'b1, 1'b1, 32'h0};
    tbl[13] = '{S_ARITH, 8'h77, 32'h5, 32'h6, 5'd16, 1'b1, 1'b1, 32'h0};
    tbl[14] = '{S_ARITH, O_ADDU, 32'h2, 32'h3, 5'd17, 1'b1, 1'b0, 32'h5};
    tbl[15] = '{S_JUMP, O_ADDU, 32'h2, 32'h3, 5'd18, 1'b0, 1'b1, 32'h0};
    tbl[16] = '{S_CMP, O_SLT, 32'h1, 32'hFFFFFFFF, 5'd19, 1'b1, 1'b1, 32'h0};
    rs = '{S_REG, S_LOGIC, S_LOGIC, S_LOGIC, S_LOGIC, S_SHIFT, S_SHIFT, S_SHIFT, S_ARITH, S_ARITH, S_CMP, S_CMP, S_SPEC};
    ro = '{O_LI, O_AND, O_OR, O_XOR, O_NOR, O_SLL, O_SRL, O_SRA, O_ADDU, O_SUBU, O_SLT, O_SLTU, 8'h00};

    rst = 1; stall_i = 0;
    drive(S_MD, O_MUL, 32'd3, 32'd4, 5'd1, 1'b1, 1'b1);
    step();
    chk("rst_req", {31'd0, stall_req_o}, 0);
    step();
    chk("rst_wdata", wdata_o, 0);
    chk("rst_waddr", {27'd0, waddr_o}, 0);
    chk("rst_we", {31'd0, we_o}, 0);
    chk("rst_valid", {31'd0, valid_o}, 0);
    rst = 0;
    valid_i = 0;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].wa, tbl[i].we, tbl[i].v);
      step();
      chk($sformatf("vec%0d_data", i), wdata_o, tbl[i].exp);
      chk($sformatf("vec%0d_waddr", i), {27'd0, waddr_o}, {27'd0, tbl[i].wa});
      chk($sformatf("vec%0d_we", i), {31'd0, we_o}, {31'd0, tbl[i].we & tbl[i].v});
      chk($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, tbl[i].v});
    end

    stall_i = 1;
    drive(S_ARITH, O_ADDU, 32'd40, 32'd2, 5'd20, 1'b1, 1'b1);
    step();
    chk("stall_hold_data", wdata_o, 0);
    chk("stall_hold_waddr", {27'd0, waddr_o}, 19);
    stall_i = 0;
    step();
    chk("stall_release", wdata_o, 42);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 12);
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      drive(rs[k], ro[k], a, b, 5'($urandom), 1'b1, 1'b1);
      step();
      chk("rand_sc", wdata_o, model(rs[k], ro[k], a, b));
    end

    run_md(O_MUL, 32'h00010003, 32'h5, 0, 1'b0, S_ARITH, O_ADDU, 32'd1, 32'd2);
    run_md(O_DIVU, 32'd100, 32'd7, 3, 1'b0, S_ARITH, O_ADDU, 32'd10, 32'd20);
    run_md(O_REMU, 32'd100, 32'd7, 0, 1'b0, S_ARITH, O_SUBU, 32'd10, 32'd3);
    run_md(O_DIVU, 32'd5, 32'd0, 1, 1'b0, S_REG, O_LI, 32'hCAFE, 32'd0);
    run_md(O_REMU, 32'd5, 32'd0, 0, 1'b0, S_CMP, O_SLTU, 32'd1, 32'd2);
    run_md(O_DIVU, 32'd1000, 32'd9, 0, 1'b0, S_LOGIC, O_OR, 32'hF0F0, 32'h0F0F);
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 2);
      run_md(k == 0 ? O_MUL : k == 1 ? O_DIVU : O_REMU, $urandom, (i == 5) ? 32'd0 : $urandom >> $urandom_range(0, 31),
             $urandom_range(0, 2), 1'b1, S_ARITH, O_ADDU, $urandom, $urandom);
    end

    drive(S_MD, O_MUL, 32'd7, 32'd9, 5'd21, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step();
    chk("pre_rst_in_run", {31'd0, stall_req_o}, 1);
    rst = 1;
    #1;
    chk("rst_run_req", {31'd0, stall_req_o}, 0);
    step();
    chk("rst_run_waddr", {27'd0, waddr_o}, 0);
    chk("rst_run_valid", {31'd0, valid_o}, 0);
    rst = 0;
    valid_i = 0;
    #1;
    chk("rst_run_idle", {31'd0, stall_req_o}, 0);
    step();
    chk("rst_run_no_write", {31'd0, valid_o}, 0);
    run_md(O_MUL, 32'h00012345, 32'h00000100, 0, 1'b0, S_LOGIC, O_AND, 32'hFF, 32'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
